// File: rtl/column_scan_reader_pkg.sv
// ============================================================================
// Module      : column_scan_reader_pkg
// Description : Shared geometry, scan state encoding and row slicing helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package column_scan_reader_pkg;

  localparam int PANELS = 5;
  localparam int ROWS   = 5;
  localparam int COLS   = 5;
  localparam int WORD_W = 25;
  localparam int COL_W  = 25;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Out-of-range rows fall back to row 0 rather than producing garbage.
  function automatic logic [COLS-1:0] row_slice(input logic [WORD_W-1:0] word,
                                                input logic [2:0]        row);
    logic [COLS-1:0] s;
    s = word[COLS-1:0];
    for (int r = 1; r < ROWS; r++) begin
      if (row == 3'(r)) s = word[r*COLS +: COLS];
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/column_scan_reader_scan_timer.sv
// ============================================================================
// Module      : column_scan_reader_scan_timer
// Description : Row slot sequencer: BLANK then SHOW per row, rows 0..4 cyclic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module column_scan_reader_scan_timer
  import column_scan_reader_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int BLANK = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  output logic [2:0]  o_row,
  output scan_state_t o_state,
  output logic        o_last_row_clk,
  output logic        o_frame_boundary
);

  localparam logic [15:0] C_DWELL_LAST = 16'(DWELL - 1);
  localparam logic [15:0] C_BLANK_LAST = 16'(BLANK - 1);
  localparam logic [2:0]  C_ROW_LAST   = 3'(ROWS - 1);

  scan_state_t r_state;
  logic [15:0] r_phase;
  logic [2:0]  r_row;
  logic [2:0]  w_row;

  assign w_row            = (r_row > C_ROW_LAST) ? 3'd0 : r_row;
  assign o_row            = w_row;
  assign o_state          = r_state;
  assign o_last_row_clk   = (r_state == ST_SHOW) && (r_phase == C_DWELL_LAST);
  assign o_frame_boundary = o_last_row_clk && (w_row == C_ROW_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_BLANK;
      r_phase <= '0;
      r_row   <= '0;
    end else if (i_enable) begin
      case (r_state)
        ST_BLANK: begin
          if (r_phase == C_BLANK_LAST) begin
            r_state <= ST_SHOW;
            r_phase <= '0;
          end else begin
            r_phase <= r_phase + 16'd1;
          end
        end
        ST_SHOW: begin
          if (r_phase == C_DWELL_LAST) begin
            r_state <= ST_BLANK;
            r_phase <= '0;
            r_row   <= (w_row == C_ROW_LAST) ? 3'd0 : w_row + 3'd1;
          end else begin
            r_phase <= r_phase + 16'd1;
          end
        end
        default: begin
          r_state <= ST_BLANK;
          r_phase <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/column_scan_reader.sv
// ============================================================================
// Module      : column_scan_reader
// Description : Frame buffer with valid/ready intake driving a row-scanned
//               5x25 LED matrix with per-row blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module column_scan_reader
  import column_scan_reader_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int BLANK = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_frame_valid,
  output logic              o_frame_ready,
  input  logic [WORD_W-1:0] i_in0,
  input  logic [WORD_W-1:0] i_in1,
  input  logic [WORD_W-1:0] i_in2,
  input  logic [WORD_W-1:0] i_in3,
  input  logic [WORD_W-1:0] i_in4,
  output logic [ROWS-1:0]   o_row_sel,
  output logic [COL_W-1:0]  o_col_data,
  output logic              o_frame_start
);

  logic [2:0]  w_row;
  scan_state_t w_state;
  logic        w_last_row_clk;
  logic        w_frame_boundary;

  column_scan_reader_scan_timer #(
    .DWELL (DWELL),
    .BLANK (BLANK)
  ) u_scan_timer (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_enable         (i_enable),
    .o_row            (w_row),
    .o_state          (w_state),
    .o_last_row_clk   (w_last_row_clk),
    .o_frame_boundary (w_frame_boundary)
  );

  logic [WORD_W-1:0] w_in      [PANELS];
  logic [WORD_W-1:0] r_active  [PANELS];
  logic [WORD_W-1:0] r_pending [PANELS];
  logic              r_pending_full;
  logic              r_frame_ready;
  logic              w_pending_full_next;
  logic              w_xfer;
  logic              w_swap;
  logic [ROWS-1:0]   w_row_sel;
  logic [COL_W-1:0]  w_col_data;
  logic [ROWS-1:0]   r_row_sel;
  logic [COL_W-1:0]  r_col_data;
  logic              r_frame_start;

  assign w_in[0] = i_in0;
  assign w_in[1] = i_in1;
  assign w_in[2] = i_in2;
  assign w_in[3] = i_in3;
  assign w_in[4] = i_in4;

  assign w_xfer = i_frame_valid & r_frame_ready;
  assign w_swap = i_enable & w_last_row_clk & w_frame_boundary;

  // A swap always empties pending; a transfer on that same cycle bypasses it.
  always_comb begin
    w_pending_full_next = r_pending_full;
    if (w_swap)      w_pending_full_next = 1'b0;
    else if (w_xfer) w_pending_full_next = 1'b1;
  end

  always_comb begin
    w_row_sel  = '0;
    w_col_data = '0;
    if (w_state == ST_SHOW) begin
      w_row_sel = ROWS'(1) << w_row;
      for (int k = 0; k < PANELS; k++) begin
        w_col_data[k*COLS +: COLS] = row_slice(r_active[k], w_row);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < PANELS; k++) begin
        r_active[k]  <= '0;
        r_pending[k] <= '0;
      end
      r_pending_full <= 1'b0;
      r_frame_ready  <= 1'b1;
      r_row_sel      <= '0;
      r_col_data     <= '0;
      r_frame_start  <= 1'b0;
    end else begin
      if (w_swap && r_pending_full) begin
        for (int k = 0; k < PANELS; k++) r_active[k] <= r_pending[k];
      end else if (w_swap && w_xfer) begin
        for (int k = 0; k < PANELS; k++) r_active[k] <= w_in[k];
      end else if (w_xfer) begin
        for (int k = 0; k < PANELS; k++) r_pending[k] <= w_in[k];
      end
      r_pending_full <= w_pending_full_next;
      r_frame_ready  <= !w_pending_full_next;
      if (i_enable) begin
        r_row_sel     <= w_row_sel;
        r_col_data    <= w_col_data;
        r_frame_start <= w_swap;
      end
    end
  end

  assign o_frame_ready = r_frame_ready;
  assign o_row_sel     = r_row_sel;
  assign o_col_data    = r_col_data;
  assign o_frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_column_scan_reader.sv
// ============================================================================
// Module      : tb_column_scan_reader
// Description : Directed scoreboard bench for column_scan_reader (DWELL=4, BLANK=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_column_scan_reader;

  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = 5 * SLOT;

  typedef struct packed {
    logic [4:0]  rs;
    logic [24:0] cd;
    logic        fs;
    logic        rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        valid = 1'b0;
  logic [24:0] in_w [5];
  logic        o_frame_ready;
  logic [4:0]  o_row_sel;
  logic [24:0] o_col_data;
  logic        o_frame_start;

  column_scan_reader #(
    .DWELL (DW),
    .BLANK (BL)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_frame_valid (valid),
    .o_frame_ready (o_frame_ready),
    .i_in0         (in_w[0]),
    .i_in1         (in_w[1]),
    .i_in2         (in_w[2]),
    .i_in3         (in_w[3]),
    .i_in4         (in_w[4]),
    .o_row_sel     (o_row_sel),
    .o_col_data    (o_col_data),
    .o_frame_start (o_frame_start)
  );

  always #5 clk = ~clk;

  // Reference state: frame position p (0 = row 0 blank start) plus buffers.
  int          m_p;
  logic [24:0] m_act  [5];
  logic [24:0] m_pend [5];
  bit          m_pfull;
  logic [4:0]  m_rs;
  logic [24:0] m_cd;
  logic        m_fs;
  logic        m_rdy;
  bit          m_xfer;
  exp_t        exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, fs_cnt = 0, fs_last = 0, fs_gap = 0, dut_xfers = 0;

  function automatic logic [24:0] cols_of(input logic [24:0] f [5], input int row);
    logic [24:0] r;
    r = '0;
    for (int k = 0; k < 5; k++)
      for (int c = 0; c < 5; c++) r[k*5+c] = f[k][row*5+c];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic rand_inputs(input bit top_bit);
    for (int k = 0; k < 5; k++) in_w[k] = 25'($urandom());
    if (top_bit) in_w[4][24] = 1'b1;
  endtask

  task automatic step();
    exp_t e;
    bit   bnd;
    int   slot, off;
    m_xfer = 1'b0;
    if (rst) begin
      m_p = 0;
      for (int k = 0; k < 5; k++) begin m_act[k] = '0; m_pend[k] = '0; end
      m_pfull = 1'b0;
      m_rs = '0; m_cd = '0; m_fs = 1'b0; m_rdy = 1'b1;
    end else begin
      if (valid && o_frame_ready) dut_xfers++;
      m_xfer = valid && !m_pfull;
      bnd    = en && (m_p == FRAME - 1);
      if (en) begin
        slot = m_p / SLOT;
        off  = m_p % SLOT;
        if (off >= BL) begin
          m_rs = 5'(1 << slot);
          m_cd = cols_of(m_act, slot);
        end else begin
          m_rs = '0;
          m_cd = '0;
        end
        m_fs = bnd;
        m_p  = (m_p + 1) % FRAME;
      end
      if (bnd && m_pfull) begin
        m_act   = m_pend;
        m_pfull = 1'b0;
      end else if (bnd && m_xfer) begin
        m_act = in_w;
      end else if (m_xfer) begin
        m_pend  = in_w;
        m_pfull = 1'b1;
      end
      m_rdy = !m_pfull;
    end
    e = '{m_rs, m_cd, m_fs, m_rdy};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    chk("row_sel",     32'(o_row_sel),     32'(e.rs));
    chk("col_data",    32'(o_col_data),    32'(e.cd));
    chk("frame_start", 32'(o_frame_start), 32'(e.fs));
    chk("frame_ready", 32'(o_frame_ready), 32'(e.rdy));
    if (o_frame_start === 1'b1) begin
      fs_cnt++;
      fs_gap  = cyc - fs_last;
      fs_last = cyc;
    end
  endtask

  initial begin
    logic [24:0] bdat [5];
    logic [24:0] acc;
    bit          found;
    bit          seen;

    for (int k = 0; k < 5; k++) in_w[k] = '0;

    // Reset
    rst = 1'b1;
    step();
    step();
    chk("reset_ready",   32'(o_frame_ready), 32'd1);
    chk("reset_row_sel", 32'(o_row_sel),     32'd0);
    rst = 1'b0;

    // Idle scan: two frame_start pulses 30 clocks apart
    fs_cnt = 0;
    repeat (65) step();
    chk("idle_fs_count", 32'(fs_cnt), 32'd2);
    chk("idle_fs_gap",   32'(fs_gap), 32'd30);

    // Single frame load mid-frame
    in_w[0] = 25'h1F;
    valid   = 1'b1;
    step();
    valid   = 1'b0;
    in_w[0] = '0;
    chk("load_ready_drop", 32'(o_frame_ready), 32'd0);
    found = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 45 && !found; i++) begin
      step();
      if (o_frame_start === 1'b1 && !seen) begin
        seen = 1'b1;
        chk("load_ready_back", 32'(o_frame_ready), 32'd1);
      end
      if (seen && o_row_sel === 5'b00001) found = 1'b1;
    end
    chk("load_row0_found", 32'(found), 32'd1);
    chk("load_row0_cols",  32'(o_col_data), 32'h1F);
    repeat (6) step();
    chk("load_row1_sel",  32'(o_row_sel),  32'd2);
    chk("load_row1_cols", 32'(o_col_data), 32'd0);

    // Back-to-back valid: one transfer per frame
    dut_xfers = 0;
    fs_cnt    = 0;
    rand_inputs(1'b1);
    valid = 1'b1;
    for (int i = 0; i < 200 && fs_cnt < 3; i++) begin
      step();
      if (m_xfer) rand_inputs(1'b1);
    end
    repeat (2) begin
      step();
      if (m_xfer) rand_inputs(1'b1);
    end
    valid = 1'b0;
    chk("b2b_transfers", 32'(dut_xfers), 32'd4);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (o_row_sel === 5'b10000) found = 1'b1;
    end
    chk("b2b_row4_found", 32'(found),         32'd1);
    chk("b2b_in4_bit24",  32'(o_col_data[24]), 32'd1);

    // Boundary bypass: valid exactly on the last SHOW clock of row 4
    for (int i = 0; i < 40 && m_pfull; i++) step();
    for (int i = 0; i < 40 && m_p != FRAME - 1; i++) step();
    rand_inputs(1'b0);
    bdat  = in_w;
    valid = 1'b1;
    step();
    valid = 1'b0;
    chk("bypass_ready", 32'(o_frame_ready), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (o_row_sel === 5'b00001) found = 1'b1;
    end
    chk("bypass_row0_found", 32'(found),      32'd1);
    chk("bypass_row0_cols",  32'(o_col_data), 32'(cols_of(bdat, 0)));

    // Enable low for 7 clocks in row 2 SHOW, with a transfer during the stall
    for (int i = 0; i < 40 && m_p != 2 * SLOT + BL + 1; i++) step();
    en = 1'b0;
    rand_inputs(1'b0);
    valid = 1'b1;
    step();
    valid = 1'b0;
    chk("stall_xfer_ready", 32'(o_frame_ready), 32'd0);
    repeat (6) step();
    chk("stall_row_hold", 32'(o_row_sel), 32'b00100);
    en = 1'b1;
    fs_cnt = 0;
    for (int i = 0; i < 60 && fs_cnt == 0; i++) step();
    chk("stall_fs_gap", 32'(fs_gap), 32'd37);

    // Reset mid-SHOW of row 3 with pending full
    rand_inputs(1'b0);
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 40 && m_p != 3 * SLOT + BL + 1; i++) step();
    chk("pre_reset_ready", 32'(o_frame_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_reset_row_sel", 32'(o_row_sel),     32'd0);
    chk("mid_reset_cols",    32'(o_col_data),    32'd0);
    chk("mid_reset_ready",   32'(o_frame_ready), 32'd1);
    acc    = '0;
    fs_cnt = 0;
    repeat (62) begin
      step();
      acc = acc | o_col_data;
    end
    chk("post_reset_blank_cols", 32'(acc),    32'd0);
    chk("post_reset_fs_count",   32'(fs_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
